// File: rtl/ram_dist_pkg.sv
// ram_dist_pkg: shared clear-FSM encoding and lane helpers for ram_dist_sdp
package ram_dist_pkg;
  localparam int MAX_W = 256;
  localparam int MAX_AW = $clog2(MAX_W);
  typedef enum logic {ST_IDLE, ST_CLEARING} state_t;
  function automatic int nlanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction
  function automatic logic [MAX_W-1:0] lane_mask(input logic [MAX_W-1:0] be, input int lane_w);
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) m[MAX_AW'(i)] = be[MAX_AW'(i / lane_w)];
    return m;
  endfunction
endpackage

// File: rtl/ram_dist_sdp_if.sv
// ram_dist_sdp_if: write, read and clear signals of ram_dist_sdp
interface ram_dist_sdp_if import ram_dist_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LANE_W = 8,
  parameter int ADDR_W = 6
);
  localparam int NLANES = nlanes(WIDTH, LANE_W);
  logic WE;
  logic CLR;
  logic BUSY;
  logic [NLANES-1:0] BE;
  logic [ADDR_W-1:0] WA;
  logic [ADDR_W-1:0] RA;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O;
  logic [WIDTH-1:0] OQ;
  modport master (output WE, BE, WA, D, RA, CLR, input O, OQ, BUSY);
  modport slave (input WE, BE, WA, D, RA, CLR, output O, OQ, BUSY);
endinterface

// File: rtl/ram_dist_clr_seq.sv
// ram_dist_clr_seq: walks every word once, issuing INIT_WORD writes while busy
module ram_dist_clr_seq import ram_dist_pkg::*; #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6
) (
  input logic clk,
  input logic rst,
  input logic clr,
  output logic busy,
  output logic clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t st = ST_IDLE;
  state_t st_nx;
  logic [ADDR_W-1:0] cnt = '0;
  logic [ADDR_W-1:0] cnt_nx;
  logic last;
  always_ff @(posedge clk) begin
    st <= rst ? ST_IDLE : st_nx;
    cnt <= rst ? '0 : cnt_nx;
  end
  always_comb begin
    last = cnt == LAST;
    st_nx = st == ST_IDLE ? (clr ? ST_CLEARING : ST_IDLE) : (last ? ST_IDLE : ST_CLEARING);
    cnt_nx = st == ST_CLEARING && !last ? cnt + 1'b1 : '0;
    busy = st == ST_CLEARING;
    clr_we = busy;
    clr_addr = cnt;
  end
endmodule

// File: rtl/ram_dist_sdp.sv
// ram_dist_sdp: simple-dual-port distributed RAM with lane enables, registered read and clear sequencer
module ram_dist_sdp import ram_dist_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int LANE_W = 8,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 6,
  parameter logic [WIDTH-1:0] INIT_WORD = '0,
  parameter bit IS_WCLK_INVERTED = 1'b1
) (
  input logic WCLK,
  input logic RST,
  ram_dist_sdp_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_A = DEPTH[ADDR_W:0];
  logic aclk;
  logic busy;
  logic clr_we;
  logic w_en;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [WIDTH-1:0] w_data;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] oq = '0;
  logic [WIDTH-1:0] mem [DEPTH] = '{default: INIT_WORD};
  assign aclk = IS_WCLK_INVERTED ? ~WCLK : WCLK;
  ram_dist_clr_seq #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_clr (
    .clk(aclk),
    .rst(RST),
    .clr(bus.CLR),
    .busy(busy),
    .clr_we(clr_we),
    .clr_addr(clr_addr)
  );
  always_comb begin
    w_en = busy ? clr_we : bus.WE && ({1'b0, bus.WA} < DEPTH_A);
    w_addr = busy ? clr_addr : bus.WA;
    w_data = busy ? INIT_WORD : bus.D;
    w_mask = busy ? '1 : WIDTH'(lane_mask(MAX_W'(bus.BE), LANE_W));
    rd = ({1'b0, bus.RA} < DEPTH_A) ? mem[bus.RA] : '0;
  end
  always_ff @(posedge aclk) begin
    if (!RST && w_en) mem[w_addr] <= (mem[w_addr] & ~w_mask) | (w_data & w_mask);
  end
  always_ff @(posedge aclk) begin
    oq <= RST ? '0 : rd;
  end
  assign bus.O = rd;
  assign bus.OQ = oq;
  assign bus.BUSY = busy;
endmodule

// File: tb/tb_ram_dist_sdp.sv
// tb_ram_dist_sdp: directed and randomized checks of ram_dist_sdp against array models
module tb_ram_dist_sdp;
  logic wclk = 1'b0;
  logic rst = 1'b0;
  int n_run = 0;
  int n_fail = 0;
  logic [7:0] ma [64];
  logic [15:0] mb [64];
  logic [7:0] mc [48];

  always #5 wclk = ~wclk;

  ram_dist_sdp_if #(.WIDTH(8), .LANE_W(8), .ADDR_W(6)) ia ();
  ram_dist_sdp_if #(.WIDTH(16), .LANE_W(8), .ADDR_W(6)) ib ();
  ram_dist_sdp_if #(.WIDTH(8), .LANE_W(8), .ADDR_W(6)) ic ();
  ram_dist_sdp_if #(.WIDTH(8), .LANE_W(8), .ADDR_W(6)) id ();

  ram_dist_sdp dut_a (.WCLK(wclk), .RST(rst), .bus(ia));
  ram_dist_sdp #(.WIDTH(16)) dut_b (.WCLK(wclk), .RST(rst), .bus(ib));
  ram_dist_sdp #(.DEPTH(48), .INIT_WORD(8'h5A)) dut_c (.WCLK(wclk), .RST(rst), .bus(ic));
  ram_dist_sdp #(.IS_WCLK_INVERTED(1'b0)) dut_d (.WCLK(wclk), .RST(rst), .bus(id));

  task automatic tick();
    @(negedge wclk);
    #1;
  endtask

  task automatic test_reset();
    n_run++;
    if (ia.OQ !== 8'h00) begin n_fail++; $display("FAIL oq_time_zero: got %h want 00", ia.OQ); end
    n_run++;
    if (ic.O !== 8'h5A) begin n_fail++; $display("FAIL init_word_time_zero: got %h want 5a", ic.O); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (ic.OQ !== 8'h00) begin n_fail++; $display("FAIL reset_oq: got %h want 00", ic.OQ); end
    n_run++;
    if (ic.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ic.BUSY); end
    n_run++;
    if (ic.O !== 8'h5A) begin n_fail++; $display("FAIL reset_keeps_mem: got %h want 5a", ic.O); end
  endtask

  task automatic test_sweep_write();
    for (int a = 0; a < 64; a++) begin
      ia.RA = 6'(a);
      #1;
      n_run++;
      if (ia.O !== ma[6'(a)]) begin n_fail++; $display("FAIL sweep_zero[%0d]: got %h want %h", a, ia.O, ma[6'(a)]); end
    end
    tick();
    ia.WE = 1'b1; ia.WA = 6'd5; ia.D = 8'hA5; ia.BE = 1'b1; ia.RA = 6'd5;
    tick();
    ia.WE = 1'b0;
    ma[5] = 8'hA5;
    n_run++;
    if (ia.O !== 8'hA5) begin n_fail++; $display("FAIL write_o_immediate: got %h want a5", ia.O); end
    n_run++;
    if (ia.OQ !== 8'h00) begin n_fail++; $display("FAIL write_oq_old: got %h want 00", ia.OQ); end
    tick();
    n_run++;
    if (ia.OQ !== 8'hA5) begin n_fail++; $display("FAIL write_oq_late: got %h want a5", ia.OQ); end
  endtask

  task automatic test_read_first();
    ia.WE = 1'b1; ia.WA = 6'd7; ia.RA = 6'd7; ia.D = 8'h11; ia.BE = 1'b1;
    tick();
    ia.WE = 1'b0;
    ma[7] = 8'h11;
    tick();
    ia.WE = 1'b1; ia.D = 8'h22;
    tick();
    ia.WE = 1'b0;
    ma[7] = 8'h22;
    n_run++;
    if (ia.OQ !== 8'h11) begin n_fail++; $display("FAIL read_first_oq: got %h want 11", ia.OQ); end
    n_run++;
    if (ia.O !== 8'h22) begin n_fail++; $display("FAIL read_first_o: got %h want 22", ia.O); end
    tick();
    n_run++;
    if (ia.OQ !== 8'h22) begin n_fail++; $display("FAIL read_first_oq_next: got %h want 22", ia.OQ); end
  endtask

  task automatic test_random_a();
    logic we, be;
    logic [5:0] wa, ra;
    logic [7:0] d, exp_oq;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom); be = 1'($urandom); wa = 6'($urandom); d = 8'($urandom);
      ra = ($urandom_range(3) == 0) ? wa : 6'($urandom);
      ia.WE = we; ia.BE = be; ia.WA = wa; ia.D = d; ia.RA = ra;
      #1;
      exp_oq = ma[ra];
      n_run++;
      if (ia.O !== exp_oq) begin n_fail++; $display("FAIL rand_a_o_pre: addr %h got %h want %h", ra, ia.O, exp_oq); end
      if (we && be) ma[wa] = d;
      tick();
      n_run++;
      if (ia.OQ !== exp_oq) begin n_fail++; $display("FAIL rand_a_oq: addr %h got %h want %h", ra, ia.OQ, exp_oq); end
      n_run++;
      if (ia.O !== ma[ra]) begin n_fail++; $display("FAIL rand_a_o_post: addr %h got %h want %h", ra, ia.O, ma[ra]); end
    end
    ia.WE = 1'b0;
  endtask

  task automatic test_lanes();
    logic we;
    logic [1:0] be;
    logic [5:0] wa, ra;
    logic [15:0] d, exp_oq;
    ib.WE = 1'b1; ib.WA = 6'd3; ib.RA = 6'd3; ib.D = 16'hFFFF; ib.BE = 2'b11;
    tick();
    ib.D = 16'h1234; ib.BE = 2'b01;
    tick();
    n_run++;
    if (ib.O !== 16'hFF34) begin n_fail++; $display("FAIL lane_low: got %h want ff34", ib.O); end
    ib.D = 16'hABCD; ib.BE = 2'b00;
    tick();
    ib.WE = 1'b0;
    mb[3] = 16'hFF34;
    n_run++;
    if (ib.O !== 16'hFF34) begin n_fail++; $display("FAIL lane_none: got %h want ff34", ib.O); end
    for (int i = 0; i < 120; i++) begin
      we = 1'($urandom); be = 2'($urandom); wa = 6'($urandom); d = 16'($urandom);
      ra = ($urandom_range(3) == 0) ? wa : 6'($urandom);
      ib.WE = we; ib.BE = be; ib.WA = wa; ib.D = d; ib.RA = ra;
      #1;
      exp_oq = mb[ra];
      n_run++;
      if (ib.O !== exp_oq) begin n_fail++; $display("FAIL rand_b_o_pre: addr %h got %h want %h", ra, ib.O, exp_oq); end
      if (we) for (int l = 0; l < 2; l++) if (be[l]) mb[wa][l*8 +: 8] = d[l*8 +: 8];
      tick();
      n_run++;
      if (ib.OQ !== exp_oq) begin n_fail++; $display("FAIL rand_b_oq: addr %h got %h want %h", ra, ib.OQ, exp_oq); end
      n_run++;
      if (ib.O !== mb[ra]) begin n_fail++; $display("FAIL rand_b_o_post: addr %h got %h want %h", ra, ib.O, mb[ra]); end
    end
    ib.WE = 1'b0;
  endtask

  task automatic test_random_c();
    logic we, be;
    logic [5:0] wa, ra;
    logic [7:0] d, exp_oq, exp_o;
    for (int i = 0; i < 150; i++) begin
      we = 1'($urandom); be = 1'($urandom); wa = 6'($urandom); d = 8'($urandom); ra = 6'($urandom);
      ic.WE = we; ic.BE = be; ic.WA = wa; ic.D = d; ic.RA = ra;
      #1;
      exp_oq = ra < 6'd48 ? mc[ra] : 8'h00;
      n_run++;
      if (ic.O !== exp_oq) begin n_fail++; $display("FAIL rand_c_o_pre: addr %h got %h want %h", ra, ic.O, exp_oq); end
      if (we && be && wa < 6'd48) mc[wa] = d;
      tick();
      exp_o = ra < 6'd48 ? mc[ra] : 8'h00;
      n_run++;
      if (ic.OQ !== exp_oq) begin n_fail++; $display("FAIL rand_c_oq: addr %h got %h want %h", ra, ic.OQ, exp_oq); end
      n_run++;
      if (ic.O !== exp_o) begin n_fail++; $display("FAIL rand_c_o_post: addr %h got %h want %h", ra, ic.O, exp_o); end
    end
    ic.WE = 1'b0;
  endtask

  task automatic fill_c();
    for (int a = 0; a < 48; a++) begin
      ic.WE = 1'b1; ic.BE = 1'b1; ic.WA = 6'(a); ic.D = 8'(a);
      tick();
      mc[6'(a)] = 8'(a);
    end
    ic.WE = 1'b0;
  endtask

  task automatic sweep_c(input string tag);
    for (int a = 0; a < 48; a++) begin
      ic.RA = 6'(a);
      #1;
      n_run++;
      if (ic.O !== mc[6'(a)]) begin n_fail++; $display("FAIL %s[%0d]: got %h want %h", tag, a, ic.O, mc[6'(a)]); end
    end
    tick();
  endtask

  task automatic test_clear();
    int cyc;
    fill_c();
    ic.CLR = 1'b1;
    tick();
    ic.CLR = 1'b0;
    n_run++;
    if (ic.BUSY !== 1'b1) begin n_fail++; $display("FAIL clr_busy_start: got %b want 1", ic.BUSY); end
    cyc = 0;
    while (ic.BUSY === 1'b1 && cyc < 100) begin
      ic.WE = 1'b1; ic.BE = 1'b1; ic.WA = 6'($urandom_range(47)); ic.D = 8'($urandom);
      ic.CLR = (cyc == 20);
      tick();
      cyc++;
    end
    ic.WE = 1'b0; ic.CLR = 1'b0;
    n_run++;
    if (cyc != 48) begin n_fail++; $display("FAIL clr_length: got %0d cycles want 48", cyc); end
    for (int a = 0; a < 48; a++) mc[6'(a)] = 8'h5A;
    sweep_c("clr_sweep");
    ic.RA = 6'd50;
    #1;
    n_run++;
    if (ic.O !== 8'h00) begin n_fail++; $display("FAIL clr_ra_oob: got %h want 00", ic.O); end
    tick();
  endtask

  task automatic test_clear_abort();
    int cyc;
    fill_c();
    ic.CLR = 1'b1; ic.WE = 1'b1; ic.BE = 1'b1; ic.WA = 6'd40; ic.D = 8'hC3; ic.RA = 6'd20;
    tick();
    ic.CLR = 1'b0; ic.WE = 1'b0;
    mc[40] = 8'hC3;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_run++;
    if (ic.BUSY !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", ic.BUSY); end
    n_run++;
    if (ic.OQ !== 8'h00) begin n_fail++; $display("FAIL abort_oq: got %h want 00", ic.OQ); end
    for (int a = 0; a < 10; a++) mc[6'(a)] = 8'h5A;
    sweep_c("abort_sweep");
    ic.CLR = 1'b1;
    tick();
    ic.CLR = 1'b0;
    cyc = 0;
    while (ic.BUSY === 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    n_run++;
    if (cyc != 48) begin n_fail++; $display("FAIL reclr_length: got %0d cycles want 48", cyc); end
    for (int a = 0; a < 48; a++) mc[6'(a)] = 8'h5A;
    sweep_c("reclr_sweep");
  endtask

  task automatic test_rising();
    @(posedge wclk);
    #1;
    id.RA = 6'd1; id.WE = 1'b1; id.WA = 6'd1; id.D = 8'h3C; id.BE = 1'b1;
    @(negedge wclk);
    #1;
    n_run++;
    if (id.O !== 8'h00) begin n_fail++; $display("FAIL rise_no_fall_write: got %h want 00", id.O); end
    @(posedge wclk);
    #1;
    id.WE = 1'b0;
    n_run++;
    if (id.O !== 8'h3C) begin n_fail++; $display("FAIL rise_commit: got %h want 3c", id.O); end
    id.RA = 6'd2;
    #3;
    id.WE = 1'b1; id.WA = 6'd2; id.D = 8'h99;
    @(negedge wclk);
    #1;
    id.WE = 1'b0;
    @(posedge wclk);
    #1;
    n_run++;
    if (id.O !== 8'h00) begin n_fail++; $display("FAIL rise_fall_pulse: got %h want 00", id.O); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 64; a++) begin ma[6'(a)] = 8'h00; mb[6'(a)] = 16'h0000; end
    for (int a = 0; a < 48; a++) mc[6'(a)] = 8'h5A;
    ia.WE = 1'b0; ia.CLR = 1'b0; ia.BE = '0; ia.WA = '0; ia.D = '0; ia.RA = '0;
    ib.WE = 1'b0; ib.CLR = 1'b0; ib.BE = '0; ib.WA = '0; ib.D = '0; ib.RA = '0;
    ic.WE = 1'b0; ic.CLR = 1'b0; ic.BE = '0; ic.WA = '0; ic.D = '0; ic.RA = '0;
    id.WE = 1'b0; id.CLR = 1'b0; id.BE = '0; id.WA = '0; id.D = '0; id.RA = '0;
    #1;
    test_reset();
    test_sweep_write();
    test_read_first();
    test_random_a();
    test_lanes();
    test_random_c();
    test_clear();
    test_clear_abort();
    test_rising();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
